// File: rtl/johnson_pkg.sv
// ---------------------------------------------------------------------------
// johnson_pkg
// Shared constants and helpers for the Johnson / ring phase sequencer family.
//
// Contents:
//   MODE_JOHNSON / MODE_RING : encoding of the run-time mode select
//   DIR_FWD / DIR_REV        : encoding of the stepping direction
//   MAX_WIDTH                : widest counter the family supports
//   reset_state()            : home state of a sequence for a given mode,
//                              returned right-aligned in MAX_WIDTH bits
// ---------------------------------------------------------------------------
package johnson_pkg;

    localparam logic MODE_JOHNSON = 1'b0;
    localparam logic MODE_RING    = 1'b1;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam int MAX_WIDTH = 16;
    localparam int MIN_WIDTH = 2;

    // Johnson sequences start from all zeros; a ring needs exactly one hot
    // bit, so its home state has only bit 0 set. Callers cast the result
    // down to their own width.
    function automatic logic [MAX_WIDTH-1:0] reset_state(input logic mode,
                                                         input int   width);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        if (mode == MODE_RING && width > 0) begin
            r[0] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// ---------------------------------------------------------------------------
// johnson_phase_decode
// Purely combinational decoder for a Johnson / ring counter state. It reports
// whether the state belongs to the selected sequence and, if so, the binary
// position of that state within the sequence.
//
// Parameters:
//   WIDTH : number of counter state bits (2..16)
//   PW    : width of the phase index (derived, not overridable)
//
// Ports:
//   count : input,  WIDTH, counter state to decode
//   mode  : input,  1,     0 = Johnson sequence, 1 = ring sequence
//   phase : output, PW,    position of count in the sequence (0 if illegal)
//   legal : output, 1,     count is a member of the selected sequence
// ---------------------------------------------------------------------------
module johnson_phase_decode
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int PW    = $clog2(2*WIDTH)
) (
    input  logic [WIDTH-1:0] count,
    input  logic             mode,
    output logic [PW-1:0]    phase,
    output logic             legal
);

    int popCount;
    int transitions;
    int hotIndex;
    int phaseInt;

    // Gather the three statistics every decision below depends on: how many
    // bits are set, how many adjacent bit pairs differ, and where the (last)
    // set bit sits.
    //
    // A legal Johnson state is a single run of ones against a run of zeros,
    // so it has at most one adjacent-bit transition. Forward from zero the
    // ones fill in from bit 0 (bit 0 set, position = number of ones); after
    // the register is full the zeros fill in from bit 0 (bit 0 clear,
    // position = 2*WIDTH - number of ones). A ring state is one-hot and its
    // position is simply the index of the hot bit.
    //
    // Illegal states report phase 0 so downstream logic never sees an
    // out-of-range index while the correction cycle is pending.
    always_comb begin
        popCount    = 0;
        transitions = 0;
        hotIndex    = 0;
        phaseInt    = 0;
        legal       = 1'b0;

        for (int i = 0; i < WIDTH; i++) begin
            if (count[i]) begin
                popCount = popCount + 1;
                hotIndex = i;
            end
        end

        for (int i = 0; i < WIDTH - 1; i++) begin
            if (count[i] != count[i+1]) begin
                transitions = transitions + 1;
            end
        end

        if (mode == MODE_RING) begin
            legal    = (popCount == 1);
            phaseInt = hotIndex;
        end else begin
            legal = (transitions <= 1);
            if (popCount == 0) begin
                phaseInt = 0;
            end else if (count[0]) begin
                phaseInt = popCount;
            end else begin
                phaseInt = 2*WIDTH - popCount;
            end
        end

        if (!legal) begin
            phaseInt = 0;
        end
    end

    assign phase = PW'(phaseInt);

endmodule

// File: rtl/johnson_ring_counter_p.sv
// ---------------------------------------------------------------------------
// johnson_ring_counter_p
// Parametrised Johnson (twisted-ring) / plain ring phase sequencer with
// enable, bidirectional stepping, run-time mode select, synchronous clear and
// self-correction of illegal states. Used as a multi-phase sequencer and
// strobe generator for downstream timing logic.
//
// Parameters:
//   WIDTH : number of state bits, 2..16
//   PW    : width of the phase index (derived, not overridable)
//
// Ports:
//   clk     : input,  1,     rising-edge clock
//   reset_n : input,  1,     asynchronous active-low reset
//   clr     : input,  1,     synchronous clear to the home state of mode
//   en      : input,  1,     step enable
//   mode    : input,  1,     0 = Johnson (2*WIDTH states), 1 = ring (WIDTH)
//   dir     : input,  1,     0 = forward, 1 = reverse
//   count   : output, WIDTH, registered counter state
//   phase   : output, PW,    binary position of count in the sequence
//   wrap    : output, 1,     one-cycle pulse after stepping across phase 0
//   err     : output, 1,     one-cycle pulse after an illegal state is fixed
// ---------------------------------------------------------------------------
module johnson_ring_counter_p
    import johnson_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int PW    = $clog2(2*WIDTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    output logic [WIDTH-1:0] count,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             err
);

    // Reject widths the decoder and package helpers were not sized for.
    if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("johnson_ring_counter_p: WIDTH must be in 2..16");
    end

    localparam logic [PW-1:0] LAST_JOHNSON = PW'(2*WIDTH - 1);
    localparam logic [PW-1:0] LAST_RING    = PW'(WIDTH - 1);

    logic             modeQ;
    logic             legal;
    logic [WIDTH-1:0] nextCount;
    logic [WIDTH-1:0] homeNewMode;
    logic [WIDTH-1:0] homeCurMode;
    logic [PW-1:0]    lastPhase;
    logic             atWrapPoint;

    // Home states: one for the mode being requested (used on clear and on a
    // mode change) and one for the mode currently running (used to repair an
    // illegal state without also switching mode).
    assign homeNewMode = WIDTH'(reset_state(mode, WIDTH));
    assign homeCurMode = WIDTH'(reset_state(modeQ, WIDTH));

    // Phase and legality are judged against the mode the counter is actually
    // running in, not the raw mode input, so a pending mode change does not
    // make the current state look illegal.
    johnson_phase_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .count (count),
        .mode  (modeQ),
        .phase (phase),
        .legal (legal)
    );

    // One step of the selected sequence. The Johnson variants feed back the
    // inverted end bit; the ring variants rotate it unchanged. Reverse steps
    // are the exact inverse of the forward ones, so flipping dir retraces
    // the previous state on the very next edge.
    always_comb begin
        nextCount = count;
        case ({modeQ, dir})
            {MODE_JOHNSON, DIR_FWD}: nextCount = {count[WIDTH-2:0], ~count[WIDTH-1]};
            {MODE_JOHNSON, DIR_REV}: nextCount = {~count[0], count[WIDTH-1:1]};
            {MODE_RING,    DIR_FWD}: nextCount = {count[WIDTH-2:0], count[WIDTH-1]};
            {MODE_RING,    DIR_REV}: nextCount = {count[0], count[WIDTH-1:1]};
            default:                 nextCount = count;
        endcase
    end

    // A step wraps when it leaves the last phase going forward or leaves
    // phase 0 going backward. Only consulted for legal states, where phase
    // is a true position.
    always_comb begin
        lastPhase   = (modeQ == MODE_RING) ? LAST_RING : LAST_JOHNSON;
        atWrapPoint = (dir == DIR_FWD) ? (phase == lastPhase) : (phase == '0);
    end

    // Main state register. Reset captures the mode input so the counter comes
    // up in the requested sequence. On each edge the actions are prioritised:
    // clear, then mode change (both jump to the new mode's home state and
    // raise no flags), then repair of an illegal state (which happens even
    // with en low and replaces the step), then a normal step, else hold.
    // wrap and err are cleared every edge so they can only ever be one-cycle
    // pulses aligned with the count they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= WIDTH'(reset_state(mode, WIDTH));
            modeQ <= mode;
            wrap  <= 1'b0;
            err   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            err  <= 1'b0;
            if (clr || (mode != modeQ)) begin
                count <= homeNewMode;
                modeQ <= mode;
            end else if (!legal) begin
                count <= homeCurMode;
                err   <= 1'b1;
            end else if (en) begin
                count <= nextCount;
                wrap  <= atWrapPoint;
            end
        end
    end

endmodule

// File: doc/johnson_ring_counter_p.md
Name: johnson_ring_counter_p

Overview:
- Parametrised successor to the team's fixed 4-bit Johnson counter. It generates twisted-ring (Johnson) or plain ring phase sequences of configurable width.
- Adds enable, bidirectional stepping, run-time mode select, synchronous clear and general illegal-state self-correction.
- Also provides a binary phase index, a wrap pulse and an error flag.
- Used as a multi-phase sequencer and strobe generator for downstream timing logic.

Parameters:
- WIDTH, 4, number of state bits; legal range 2..16.
- PW, $clog2(2*WIDTH), width of the phase index output. Localparam, not overridable.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- clr, input, 1, synchronous clear to the reset state of the current mode.
- en, input, 1, step enable.
- mode, input, 1, 0 = Johnson (sequence length 2*WIDTH), 1 = ring (sequence length WIDTH).
- dir, input, 1, 0 = forward, 1 = reverse.
- count, output, WIDTH, registered counter state.
- phase, output, PW, binary position of count in the current sequence.
- wrap, output, 1, registered one-cycle pulse on sequence wrap.
- err, output, 1, registered one-cycle pulse when an illegal state is corrected.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - count = 0 if mode=0, or 1 (bit0 set) if mode=1, using mode as sampled at reset.
  - wrap=0, err=0.
  - Internal mode_q is loaded with mode.
- Reset state per mode (R): Johnson R = all zeros; ring R = 0..01.
- Step functions (one step per clk while en=1):
  - Johnson fwd: count <= {count[W-2:0], ~count[W-1]}.
  - Johnson rev: count <= {~count[0], count[W-1:1]}.
  - Ring fwd: count <= {count[W-2:0], count[W-1]}.
  - Ring rev: count <= {count[0], count[W-1:1]}.
- Legality, evaluated combinationally on count against mode_q:
  - Johnson: legal iff at most one adjacent-bit transition across count[i] vs count[i+1], i=0..W-2.
  - Ring: legal iff popcount(count)==1.
- Per-edge priority, highest first:
  1. clr: count <= R(mode); mode_q <= mode; wrap=0; err=0.
  2. mode != mode_q: count <= R(mode); mode_q <= mode; no err, no wrap.
  3. count illegal: count <= R(mode_q); err=1 next cycle. Correction happens regardless of en, and no step is taken.
  4. en=1: step per dir.
  5. Otherwise: hold.
- err and wrap default to 0 every cycle; each is only a one-cycle pulse.
- wrap:
  - Set the cycle after a priority-4 step from the last phase to phase 0 (fwd), or from phase 0 to the last phase (rev).
  - Last phase = 2W-1 (Johnson) or W-1 (ring).
- phase, combinational from registered count:
  - Johnson: 0 if count==0; popcount if count[0]=1; else 2W - popcount.
  - Ring: index of the set bit.
  - While count is illegal: phase=0.
- Latency: count changes one clk after en, clr or a mode change is sampled. phase follows count with zero delay. wrap and err align with the resulting count.
- Reset asserted mid-sequence aborts immediately. There is no pending correction or wrap after release.
- dir may toggle every cycle. The counter retraces with no extra-cycle penalty.

Decomposition:
- Shared package johnson_pkg holds:
  - MODE_JOHNSON=1'b0, MODE_RING=1'b1, DIR_FWD=1'b0, DIR_REV=1'b1.
  - A function reset_state(mode, width).
- One natural sub-module: johnson_phase_decode. It is combinational and contains count-to-phase conversion plus the legality check. It is parametrised by WIDTH and reused by future multi-phase clock-enable blocks.

Test Plan:
1. W=4, mode=0, dir=0, en=1 from reset, for 9 clks -> count 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; phase 0..7 then 0; wrap=1 only in the cycle count returns to 0000.
2. W=4, Johnson at 0011, dir=1 for 3 clks -> 0001, 0000, 1000; phase 1, 0, 7; wrap=1 with 1000.
3. Force count=0101 (Johnson) with en=0 -> next clk count=0000, err=1 for one cycle, phase=0. Repeat in ring mode with 0110 -> 0001, err=1.
4. W=4, mode=1, en=1, dir=0, 5 clks -> 0001, 0010, 0100, 1000, 0001; wrap with the final 0001. Switch mode to 0 mid-run at 0100 -> next count=0000, err=0.
5. Johnson at 0111, clr=1 together with en=1 and an illegal-free state -> count=0000, wrap=0. Assert reset_n=0 between edges -> count=0000 immediately, without waiting for a clk edge.
6. W=8 regression: forward run of 16 steps -> the full 16-state sequence is checked against a model; 32 random illegal injections each recover in exactly 1 clk.
